hpi_target: RTL and testbench
=============================

Name: hpi_target

Overview:
- Synthesizable responder for the 4-register CY7C67200-style HPI bus: the device end of the same bus our host-side HPI I/O interface drives.
- Decodes CS_N/RD_N/WR_N strobes and ADDR[1:0], serves an internal word RAM through an auto-incrementing address pointer, and provides bidirectional mailboxes with an interrupt to the host.
- Used as an on-chip device emulator and as the loopback target for HPI driver bring-up.

Parameters:
AW, 10, RAM word-address width (RAM depth = 2^AW 16-bit words)

Ports:
Clk  input  1  system clock; all logic rising-edge
Reset  input  1  asynchronous, active-high reset
HPI_ADDR  input  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
HPI_CS_N  input  1  chip select, active low
HPI_RD_N  input  1  read strobe, active low
HPI_WR_N  input  1  write strobe, active low
HPI_DATA_IN  input  16  host write data (input side of tri-state pad)
HPI_DATA_OUT  output  16  read data to pad
HPI_DATA_OE  output  1  pad output enable, active high
HPI_INT  output  1  interrupt to host, active high
mbx_from_local  input  16  local-to-host mailbox data
mbx_from_local_wr  input  1  one-cycle pulse: load mbx_from_local
mbx_to_local  output  16  host-to-local mailbox data
mbx_to_local_valid  output  1  host mailbox word pending
mbx_to_local_ack  input  1  one-cycle pulse: local consumed mailbox

Behaviour:
- Clocking/reset: one clock domain; Reset asynchronous, active high.
- Reset values: HPI_DATA_OUT=0, HPI_DATA_OE=0, HPI_INT=0, mbx_to_local=0, mbx_to_local_valid=0, ptr=0, host mailbox=0, STATUS=0, FSM=IDLE.
- RAM contents are not reset.
- Reset asserted mid-access forces OE low immediately; the access is abandoned.
- Strobe conditions: strobe_rd = ~CS_N & ~RD_N & WR_N; strobe_wr = ~CS_N & ~WR_N & RD_N; both = ~CS_N & ~RD_N & ~WR_N.
- FSM states: IDLE, READ, WRITE, WAIT_REL.
- IDLE:
  - strobe_rd: latch ADDR, go to READ.
  - strobe_wr: latch ADDR and DATA_IN, go to WRITE.
  - both: set STATUS[2] (proto_err), go to WAIT_REL with no access.
  - Otherwise stay in IDLE.
- READ (exactly 1 cycle): load HPI_DATA_OUT from the selected register, set OE=1, go to WAIT_REL.
  - DATA returns RAM[ptr[AW:1]], then ptr += 2.
  - MAILBOX returns the host mailbox, clears STATUS[0], clears INT.
  - ADDRESS returns ptr.
  - STATUS returns {12'b0, STATUS[3:0]}.
- WRITE (exactly 1 cycle), then go to WAIT_REL:
  - DATA: RAM[ptr[AW:1]] <= data, ptr += 2.
  - MAILBOX: mbx_to_local <= data, valid=1. If valid was already 1, set STATUS[3] (overrun) and overwrite.
  - ADDRESS: ptr <= data.
  - STATUS: write-1-to-clear bits 2 and 3; bits 0 and 1 are read-only.
- WAIT_REL: hold HPI_DATA_OUT. When CS_N=1 or (RD_N=1 & WR_N=1), clear OE at the next edge and go to IDLE. One strobe equals exactly one access regardless of strobe length.
- Latency: strobe first sampled at edge N → HPI_DATA_OUT valid and OE=1 after edge N+1. The host must hold RD_N low for at least 3 clocks. Write commit completes at edge N+1.
- ptr arithmetic: 16-bit, wraps 0xFFFE → 0x0000. ptr[0] is ignored for indexing. RAM aliases modulo 2^(AW+1) bytes.
- STATUS bits: [0] mbx_in_full, [1] mbx_out_full (= mbx_to_local_valid), [2] proto_err, [3] mbx_overrun.
- Local mailbox write: mbx_from_local_wr loads the host mailbox, sets STATUS[0] and HPI_INT. HPI_INT == STATUS[0].
- Simultaneous events:
  - mbx_from_local_wr in the same cycle as a READ of MAILBOX: host receives the old value; the new value loads and STATUS[0]/INT stay set.
  - mbx_to_local_ack in the same cycle as a WRITE to MAILBOX: the write wins, valid stays 1, no overrun.
  - Ack while valid=0: ignored.

Test Plan:
1. Reset, write ADDRESS=0x0010, write DATA 0xAAAA then 0x5555, write ADDRESS=0x0010, read DATA twice → 0xAAAA then 0x5555; read ADDRESS → 0x0014.
2. Hold RD_N low 10 clocks on DATA → exactly one ptr increment. OE rises 2 edges after the strobe is sampled and falls 1 edge after RD_N returns high.
3. Pulse mbx_from_local_wr with 0x1234 → INT=1, STATUS=0x0001; host read MAILBOX → 0x1234, then INT=0, STATUS=0x0000.
4. Host writes MAILBOX 0xBEEF twice without ack → mbx_to_local=0xBEEF, valid=1, STATUS=0x000A; write STATUS 0x0008 → STATUS=0x0002; ack → valid=0.
5. Assert RD_N and WR_N together with CS_N low → no RAM/ptr change, STATUS[2]=1, OE stays 0. Write ADDRESS=0xFFFE, then a DATA write → ptr reads back 0x0000.
6. Assert Reset during WAIT_REL of a read → OE=0 and INT=0 immediately; STATUS=0 and ptr=0 after release.

Source files
------------

// File: rtl/hpi_target.sv
// ---------------------------------------------------------------------------
// hpi_target
//   Device-side responder for the 4-register CY7C67200-style HPI bus. Decodes
//   the host's CS_N/RD_N/WR_N strobes, serves a 16-bit word RAM through an
//   auto-incrementing byte pointer, and exposes a mailbox pair with a host
//   interrupt. One strobe assertion produces exactly one register access.
//
// Ports:
//   Clk, Reset            clock (rising edge), async active-high reset
//   HPI_ADDR[1:0]         register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   HPI_CS_N/RD_N/WR_N    active-low host strobes
//   HPI_DATA_IN[15:0]     host write data from the pad
//   HPI_DATA_OUT[15:0]    read data to the pad, HPI_DATA_OE its enable
//   HPI_INT               host interrupt, mirrors STATUS[0]
//   mbx_from_local*       local side loads the host-bound mailbox
//   mbx_to_local*         host-written mailbox word, valid flag, local ack
// ---------------------------------------------------------------------------
module hpi_target #(
    parameter int AW = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  HPI_ADDR,
    input  logic        HPI_CS_N,
    input  logic        HPI_RD_N,
    input  logic        HPI_WR_N,
    input  logic [15:0] HPI_DATA_IN,
    output logic [15:0] HPI_DATA_OUT,
    output logic        HPI_DATA_OE,
    output logic        HPI_INT,
    input  logic [15:0] mbx_from_local,
    input  logic        mbx_from_local_wr,
    output logic [15:0] mbx_to_local,
    output logic        mbx_to_local_valid,
    input  logic        mbx_to_local_ack
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT_REL} state_e;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_MAILBOX = 2'd1;
    localparam logic [1:0] REG_ADDRESS = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    state_e      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] host_mbx_q, host_mbx_d;
    logic        in_full_q, in_full_d;
    logic        proto_err_q, proto_err_d;
    logic        overrun_q, overrun_d;
    logic [15:0] to_local_q, to_local_d;
    logic        to_local_valid_q, to_local_valid_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        ram_we;

    logic [15:0] mem [0:(2**AW)-1];
    logic [AW-1:0] ram_idx;
    logic [3:0]    status;
    logic          strobe_rd, strobe_wr, strobe_both;

    // ptr is a byte address; bit 0 is dropped and upper bits alias.
    assign ram_idx = ptr_q[AW:1];
    assign status  = {overrun_q, proto_err_q, to_local_valid_q, in_full_q};

    assign strobe_rd   = ~HPI_CS_N & ~HPI_RD_N &  HPI_WR_N;
    assign strobe_wr   = ~HPI_CS_N & ~HPI_WR_N &  HPI_RD_N;
    assign strobe_both = ~HPI_CS_N & ~HPI_RD_N & ~HPI_WR_N;

    // NOTE: every signal written here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        ptr_d            = ptr_q;
        host_mbx_d       = host_mbx_q;
        in_full_d        = in_full_q;
        proto_err_d      = proto_err_q;
        overrun_d        = overrun_q;
        to_local_d       = to_local_q;
        to_local_valid_d = to_local_valid_q;
        dout_d           = dout_q;
        oe_d             = oe_q;
        ram_we           = 1'b0;

        // Local ack is applied first so a same-cycle host mailbox write wins.
        if (mbx_to_local_ack) begin
            to_local_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (strobe_both) begin
                    proto_err_d = 1'b1;
                    state_d     = WAIT_REL;
                end else if (strobe_rd) begin
                    addr_d  = HPI_ADDR;
                    state_d = READ;
                end else if (strobe_wr) begin
                    addr_d  = HPI_ADDR;
                    wdata_d = HPI_DATA_IN;
                    state_d = WRITE;
                end
            end

            READ: begin
                oe_d    = 1'b1;
                state_d = WAIT_REL;
                unique case (addr_q)
                    REG_DATA: begin
                        dout_d = mem[ram_idx];
                        ptr_d  = ptr_q + 16'd2;
                    end
                    REG_MAILBOX: begin
                        dout_d    = host_mbx_q;
                        in_full_d = 1'b0;
                    end
                    REG_ADDRESS: dout_d = ptr_q;
                    REG_STATUS:  dout_d = {12'b0, status};
                endcase
            end

            WRITE: begin
                state_d = WAIT_REL;
                unique case (addr_q)
                    REG_DATA: begin
                        ram_we = 1'b1;
                        ptr_d  = ptr_q + 16'd2;
                    end
                    REG_MAILBOX: begin
                        // An ack in this same cycle means the old word was consumed.
                        if (to_local_valid_q && !mbx_to_local_ack) begin
                            overrun_d = 1'b1;
                        end
                        to_local_d       = wdata_q;
                        to_local_valid_d = 1'b1;
                    end
                    REG_ADDRESS: ptr_d = wdata_q;
                    REG_STATUS: begin
                        if (wdata_q[2]) proto_err_d = 1'b0;
                        if (wdata_q[3]) overrun_d   = 1'b0;
                    end
                endcase
            end

            WAIT_REL: begin
                // Wait for the strobe to end so a long strobe is one access.
                if (HPI_CS_N || (HPI_RD_N && HPI_WR_N)) begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        // Applied last: a same-cycle host MAILBOX read sees the old word via
        // host_mbx_q, while the new word and the full flag still land.
        if (mbx_from_local_wr) begin
            host_mbx_d = mbx_from_local;
            in_full_d  = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            ptr_q            <= '0;
            host_mbx_q       <= '0;
            in_full_q        <= 1'b0;
            proto_err_q      <= 1'b0;
            overrun_q        <= 1'b0;
            to_local_q       <= '0;
            to_local_valid_q <= 1'b0;
            dout_q           <= '0;
            oe_q             <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            ptr_q            <= ptr_d;
            host_mbx_q       <= host_mbx_d;
            in_full_q        <= in_full_d;
            proto_err_q      <= proto_err_d;
            overrun_q        <= overrun_d;
            to_local_q       <= to_local_d;
            to_local_valid_q <= to_local_valid_d;
            dout_q           <= dout_d;
            oe_q             <= oe_d;
        end
    end

    // NOTE: the RAM has no reset so it maps onto plain memory; its contents
    // are undefined until the host writes them.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[ram_idx] <= wdata_q;
        end
    end

    assign HPI_DATA_OUT       = dout_q;
    assign HPI_DATA_OE        = oe_q;
    assign HPI_INT            = in_full_q;
    assign mbx_to_local       = to_local_q;
    assign mbx_to_local_valid = to_local_valid_q;

endmodule

// File: tb/tb_hpi_target.sv
// ---------------------------------------------------------------------------
// tb_hpi_target
//   Self-checking bench for hpi_target. Inputs are driven and outputs sampled
//   on the falling clock edge. A vector table covers basic register traffic;
//   hand-written sequences cover strobe timing, mailbox races, protocol
//   errors, pointer wrap and reset during an access.
// ---------------------------------------------------------------------------
module tb_hpi_target;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  HPI_ADDR;
    logic        HPI_CS_N, HPI_RD_N, HPI_WR_N;
    logic [15:0] HPI_DATA_IN;
    logic [15:0] HPI_DATA_OUT;
    logic        HPI_DATA_OE;
    logic        HPI_INT;
    logic [15:0] mbx_from_local;
    logic        mbx_from_local_wr;
    logic [15:0] mbx_to_local;
    logic        mbx_to_local_valid;
    logic        mbx_to_local_ack;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [15:0] data;   // write data, or expected read data
    } vec_t;

    hpi_target #(.AW(10)) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .HPI_ADDR           (HPI_ADDR),
        .HPI_CS_N           (HPI_CS_N),
        .HPI_RD_N           (HPI_RD_N),
        .HPI_WR_N           (HPI_WR_N),
        .HPI_DATA_IN        (HPI_DATA_IN),
        .HPI_DATA_OUT       (HPI_DATA_OUT),
        .HPI_DATA_OE        (HPI_DATA_OE),
        .HPI_INT            (HPI_INT),
        .mbx_from_local     (mbx_from_local),
        .mbx_from_local_wr  (mbx_from_local_wr),
        .mbx_to_local       (mbx_to_local),
        .mbx_to_local_valid (mbx_to_local_valid),
        .mbx_to_local_ack   (mbx_to_local_ack)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge Clk);
        HPI_ADDR = a; HPI_DATA_IN = d; HPI_CS_N = 1'b0; HPI_WR_N = 1'b0;
        repeat (3) @(negedge Clk);
        HPI_CS_N = 1'b1; HPI_WR_N = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic host_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
        @(negedge Clk);
        HPI_ADDR = a; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        repeat (3) @(negedge Clk);
        d  = HPI_DATA_OUT;
        oe = HPI_DATA_OE;
        HPI_CS_N = 1'b1; HPI_RD_N = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        oe;
        host_read(a, d, oe);
        check(name, d, exp);
    endtask

    task automatic local_write(input logic [15:0] d);
        @(negedge Clk);
        mbx_from_local = d; mbx_from_local_wr = 1'b1;
        @(negedge Clk);
        mbx_from_local_wr = 1'b0;
    endtask

    task automatic local_ack();
        @(negedge Clk);
        mbx_to_local_ack = 1'b1;
        @(negedge Clk);
        mbx_to_local_ack = 1'b0;
    endtask

    vec_t vecs [13];

    initial begin
        logic [15:0] d;
        logic        oe;

        vecs[0]  = '{1'b1, A_ADDR, 16'h0010};
        vecs[1]  = '{1'b1, A_DATA, 16'hAAAA};
        vecs[2]  = '{1'b1, A_DATA, 16'h5555};
        vecs[3]  = '{1'b1, A_ADDR, 16'h0010};
        vecs[4]  = '{1'b0, A_DATA, 16'hAAAA};
        vecs[5]  = '{1'b0, A_DATA, 16'h5555};
        vecs[6]  = '{1'b0, A_ADDR, 16'h0014};
        vecs[7]  = '{1'b1, A_ADDR, 16'h0000};
        vecs[8]  = '{1'b1, A_DATA, 16'h0123};
        vecs[9]  = '{1'b1, A_ADDR, 16'h0800};   // aliases byte 0 with AW=10
        vecs[10] = '{1'b0, A_DATA, 16'h0123};
        vecs[11] = '{1'b0, A_ADDR, 16'h0802};
        vecs[12] = '{1'b0, A_STAT, 16'h0000};

        Reset = 1'b1;
        HPI_ADDR = '0; HPI_CS_N = 1'b1; HPI_RD_N = 1'b1; HPI_WR_N = 1'b1;
        HPI_DATA_IN = '0; mbx_from_local = '0; mbx_from_local_wr = 1'b0;
        mbx_to_local_ack = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Reset state
        check("rst_dout",  HPI_DATA_OUT, 16'h0000);
        check("rst_oe",    {15'b0, HPI_DATA_OE}, 16'h0000);
        check("rst_int",   {15'b0, HPI_INT}, 16'h0000);
        check("rst_mbx",   mbx_to_local, 16'h0000);
        check("rst_valid", {15'b0, mbx_to_local_valid}, 16'h0000);

        // Register traffic from the vector table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                host_write(vecs[i].addr, vecs[i].data);
            end else begin
                host_read(vecs[i].addr, d, oe);
                check($sformatf("vec%0d_data", i), d, vecs[i].data);
                check($sformatf("vec%0d_oe", i), {15'b0, oe}, 16'h0001);
            end
        end

        // Long read strobe: one access, OE timing
        host_write(A_ADDR, 16'h0020);
        host_write(A_DATA, 16'h1357);
        host_write(A_ADDR, 16'h0020);
        @(negedge Clk);
        HPI_ADDR = A_DATA; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        @(negedge Clk);
        check("long_oe_edge1", {15'b0, HPI_DATA_OE}, 16'h0000);
        @(negedge Clk);
        check("long_oe_edge2", {15'b0, HPI_DATA_OE}, 16'h0001);
        check("long_data", HPI_DATA_OUT, 16'h1357);
        repeat (8) @(negedge Clk);
        check("long_oe_held", {15'b0, HPI_DATA_OE}, 16'h0001);
        HPI_CS_N = 1'b1; HPI_RD_N = 1'b1;
        @(negedge Clk);
        check("long_oe_fall", {15'b0, HPI_DATA_OE}, 16'h0000);
        @(negedge Clk);
        read_check("long_ptr", A_ADDR, 16'h0022);

        // Local-to-host mailbox and interrupt
        local_write(16'h1234);
        check("int_set", {15'b0, HPI_INT}, 16'h0001);
        read_check("stat_in_full", A_STAT, 16'h0001);
        read_check("mbx_read", A_MBX, 16'h1234);
        check("int_clr", {15'b0, HPI_INT}, 16'h0000);
        read_check("stat_after_mbx", A_STAT, 16'h0000);

        // Local write racing a host MAILBOX read: host sees the old word
        local_write(16'h0AAA);
        @(negedge Clk);
        HPI_ADDR = A_MBX; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        @(negedge Clk);
        mbx_from_local = 16'h0BBB; mbx_from_local_wr = 1'b1;
        @(negedge Clk);
        mbx_from_local_wr = 1'b0;
        check("race_old_word", HPI_DATA_OUT, 16'h0AAA);
        check("race_int_kept", {15'b0, HPI_INT}, 16'h0001);
        @(negedge Clk);
        HPI_CS_N = 1'b1; HPI_RD_N = 1'b1;
        repeat (2) @(negedge Clk);
        read_check("race_new_word", A_MBX, 16'h0BBB);
        check("race_int_clr", {15'b0, HPI_INT}, 16'h0000);

        // Host-to-local mailbox overrun and W1C
        host_write(A_MBX, 16'hBEEF);
        host_write(A_MBX, 16'hBEEF);
        check("h2l_data", mbx_to_local, 16'hBEEF);
        check("h2l_valid", {15'b0, mbx_to_local_valid}, 16'h0001);
        read_check("stat_overrun", A_STAT, 16'h000A);
        host_write(A_STAT, 16'h0008);
        read_check("stat_w1c", A_STAT, 16'h0002);
        local_ack();
        check("h2l_acked", {15'b0, mbx_to_local_valid}, 16'h0000);
        local_ack();   // ack with nothing pending is ignored
        read_check("stat_idle_ack", A_STAT, 16'h0000);

        // Ack in the same cycle as a host MAILBOX write: write wins, no overrun
        host_write(A_MBX, 16'h1111);
        @(negedge Clk);
        HPI_ADDR = A_MBX; HPI_DATA_IN = 16'h2222; HPI_CS_N = 1'b0; HPI_WR_N = 1'b0;
        @(negedge Clk);
        mbx_to_local_ack = 1'b1;
        @(negedge Clk);
        mbx_to_local_ack = 1'b0;
        @(negedge Clk);
        HPI_CS_N = 1'b1; HPI_WR_N = 1'b1;
        repeat (2) @(negedge Clk);
        check("ackrace_data", mbx_to_local, 16'h2222);
        check("ackrace_valid", {15'b0, mbx_to_local_valid}, 16'h0001);
        read_check("ackrace_stat", A_STAT, 16'h0002);
        local_ack();

        // Both strobes at once: protocol error, no access
        host_write(A_ADDR, 16'h0040);
        host_write(A_DATA, 16'h7777);
        host_write(A_ADDR, 16'h0040);
        @(negedge Clk);
        HPI_ADDR = A_DATA; HPI_DATA_IN = 16'hDEAD;
        HPI_CS_N = 1'b0; HPI_RD_N = 1'b0; HPI_WR_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("both_oe%0d", i), {15'b0, HPI_DATA_OE}, 16'h0000);
        end
        HPI_CS_N = 1'b1; HPI_RD_N = 1'b1; HPI_WR_N = 1'b1;
        repeat (2) @(negedge Clk);
        read_check("both_ptr", A_ADDR, 16'h0040);
        read_check("both_stat", A_STAT, 16'h0004);
        read_check("both_ram", A_DATA, 16'h7777);
        host_write(A_STAT, 16'h0004);
        read_check("proto_w1c", A_STAT, 16'h0000);

        // Pointer wrap at 0xFFFE and the aliased RAM location
        host_write(A_ADDR, 16'hFFFE);
        host_write(A_DATA, 16'h9999);
        read_check("ptr_wrap", A_ADDR, 16'h0000);
        host_write(A_ADDR, 16'h07FE);
        read_check("wrap_alias", A_DATA, 16'h9999);

        // Reset during WAIT_REL of a read
        local_write(16'h4321);
        @(negedge Clk);
        HPI_ADDR = A_STAT; HPI_CS_N = 1'b0; HPI_RD_N = 1'b0;
        repeat (3) @(negedge Clk);
        check("pre_rst_oe", {15'b0, HPI_DATA_OE}, 16'h0001);
        #1 Reset = 1'b1;
        #1;
        check("rst_mid_oe", {15'b0, HPI_DATA_OE}, 16'h0000);
        check("rst_mid_int", {15'b0, HPI_INT}, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        HPI_CS_N = 1'b1; HPI_RD_N = 1'b1;
        repeat (2) @(negedge Clk);
        read_check("rst_mid_stat", A_STAT, 16'h0000);
        read_check("rst_mid_ptr", A_ADDR, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
